// File: rtl/qeciphy_rx_frame_aligner.sv
// qeciphy_rx_frame_aligner
// Finds the Frame Alignment Word in the raw RX word stream, confirms it with a
// hunt/verify/locked state machine, and re-emits the stream one cycle later with
// frame / CRC-group boundary strobes and a lock enable for the RX data monitor.
// Optional build macro: QECIPHY_RX_ALIGN_STATS_EN adds saturating miss and
// lock-loss counters; without it both count ports are tied to zero.
//
// state  | meaning
// HUNT   | every word is tested for the FAW
// VERIFY | FAW found; checking that it repeats every FAW_PERIOD words
// LOCKED | aligned; strobes valid, consecutive misses counted toward loss of lock

`timescale 1ns/1ps

package qeciphy_pkg;
  localparam logic [63:0] FAW_WORD = 64'hA5C3_5A3C_0FF0_F00F;

  function automatic logic is_faw(input logic [63:0] word);
    return word == FAW_WORD;
  endfunction
endpackage

module qeciphy_rx_frame_aligner #(
  parameter int FAW_PERIOD   = 64,
  parameter int CRC_PERIOD   = 7,
  parameter int VERIFY_COUNT = 3,
  parameter int LOSS_COUNT   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [63:0] tdata_i,
  output logic [63:0] tdata_o,
  output logic        faw_boundary_o,
  output logic        crc_boundary_o,
  output logic        locked_o,
  output logic        lock_lost_o,
  output logic [15:0] faw_miss_count_o,
  output logic [15:0] lock_loss_count_o
);

  localparam int POS_W   = (FAW_PERIOD > 1) ? $clog2(FAW_PERIOD) : 1;
  localparam int CRC_W   = (CRC_PERIOD > 1) ? $clog2(CRC_PERIOD) : 1;
  localparam int MATCH_W = $clog2(VERIFY_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

  localparam logic [POS_W-1:0]   POS_LAST    = POS_W'(FAW_PERIOD - 1);
  localparam logic [CRC_W-1:0]   CRC_LAST    = CRC_W'(CRC_PERIOD - 1);
  localparam logic [MATCH_W-1:0] MATCH_FINAL = MATCH_W'(VERIFY_COUNT - 1);
  localparam logic [MISS_W-1:0]  MISS_FINAL  = MISS_W'(LOSS_COUNT - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [POS_W-1:0]     pos_q, pos_d, pos_inc;
  // crc_q tracks (pos-1) mod CRC_PERIOD so no divider is needed; it sits at
  // CRC_LAST on frame position 0 so that position 1 lands on 0.
  logic [CRC_W-1:0]     crc_q, crc_d, crc_inc;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic                 lock_lost_d;
  logic                 locked_d;
  logic                 faw_hit;
  logic                 pos_at_faw;

  assign faw_hit    = qeciphy_pkg::is_faw(tdata_i);
  assign pos_inc    = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
  assign crc_inc    = (pos_q == POS_LAST) ? CRC_LAST :
                      ((crc_q == CRC_LAST) ? '0 : crc_q + 1'b1);
  assign pos_at_faw = (pos_inc == '0);

  // Next-state evaluation of the current input word.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_inc;
    crc_d       = crc_inc;
    match_d     = match_q;
    miss_d      = miss_q;
    lock_lost_d = 1'b0;
    if (!enable_i) begin
      state_d = HUNT;
      pos_d   = '0;
      crc_d   = CRC_LAST;
      match_d = '0;
      miss_d  = '0;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (faw_hit) begin
            state_d = VERIFY;
            pos_d   = '0;
            crc_d   = CRC_LAST;
            match_d = MATCH_W'(1);
          end
        end
        VERIFY: begin
          if (pos_at_faw) begin
            if (!faw_hit) begin
              state_d = HUNT;
              match_d = '0;
            end else if (match_q == MATCH_FINAL) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (pos_at_faw) begin
            if (faw_hit) begin
              miss_d = '0;
            end else if (miss_q == MISS_FINAL) begin
              state_d     = HUNT;
              miss_d      = '0;
              lock_lost_d = 1'b1;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = HUNT;
          pos_d   = '0;
          crc_d   = CRC_LAST;
          match_d = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  assign locked_d = (state_d == LOCKED);

  // State registers and the registered, mutually aligned output stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= HUNT;
      pos_q          <= '0;
      crc_q          <= CRC_LAST;
      match_q        <= '0;
      miss_q         <= '0;
      tdata_o        <= '0;
      faw_boundary_o <= 1'b0;
      crc_boundary_o <= 1'b0;
      locked_o       <= 1'b0;
      lock_lost_o    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      crc_q          <= crc_d;
      match_q        <= match_d;
      miss_q         <= miss_d;
      tdata_o        <= tdata_i;
      faw_boundary_o <= locked_d && (pos_d == '0);
      crc_boundary_o <= locked_d && (pos_d != '0) && (crc_d == '0);
      locked_o       <= locked_d;
      lock_lost_o    <= lock_lost_d;
    end
  end

`ifdef QECIPHY_RX_ALIGN_STATS_EN
  logic [15:0] faw_miss_cnt_q;
  logic [15:0] lock_loss_cnt_q;
  logic        miss_evt;

  assign miss_evt = enable_i && (state_q == LOCKED) && pos_at_faw && !faw_hit;

  // Saturating diagnostics counters; enable_i deliberately does not clear them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      faw_miss_cnt_q  <= '0;
      lock_loss_cnt_q <= '0;
    end else begin
      if (miss_evt && (faw_miss_cnt_q != 16'hFFFF)) begin
        faw_miss_cnt_q <= faw_miss_cnt_q + 16'd1;
      end
      if (lock_lost_d && (lock_loss_cnt_q != 16'hFFFF)) begin
        lock_loss_cnt_q <= lock_loss_cnt_q + 16'd1;
      end
    end
  end

  assign faw_miss_count_o  = faw_miss_cnt_q;
  assign lock_loss_count_o = lock_loss_cnt_q;
`else
  assign faw_miss_count_o  = '0;
  assign lock_loss_count_o = '0;
`endif

endmodule
